// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access-size encodings,
// controller FSM states and the byte-lane helpers used by the store path.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-lane mask for a store of the given size at the (already aligned) low address bits.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    be = '0;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane it could land in,
  // so the byte-enable mask alone decides what is written.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data path: picks the addressed byte/half out of a 32-bit word and
// sign- or zero-extends it. Word loads pass through untouched.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension to 32 bits.
  // NOTE: every output of a combinational block gets a default before any branch, so no latch can be inferred.
  always_comb begin
    byte_sel = '0;
    half_sel = '0;
    data_o   = '0;
    case (lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = lo_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      SZ_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Synchronous data memory for the MEM stage with a valid/ready request port,
// LATENCY-cycle response and error reporting for bad accesses.
// Build option: define DMEM_ALIGN_CHECK_EN to report misaligned half/word
// accesses as errors; otherwise misaligned accesses are silently aligned.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH) << 2;

  logic [31:0] mem_array [DEPTH];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hold_q, hold_d;
  logic [1:0]       lo_q, lo_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic             accept;
  logic             req_err;
  logic [1:0]       eff_lo;
  logic [IDX_W-1:0] word_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_lanes;
  logic [31:0]      load_data;

  assign req_ready  = (state_q == ST_IDLE);
  assign accept     = req_valid && req_ready && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // Request decode: word index, effective low address bits and error conditions.
  always_comb begin
    word_idx = req_addr[IDX_W+1:2];
    eff_lo   = req_addr[1:0];
    req_err  = (req_size == SZ_RSVD) || ({1'b0, req_addr} >= ADDR_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    if ((req_size == SZ_HALF && req_addr[0]) ||
        (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
    end
`else
    if (req_size == SZ_HALF) begin
      eff_lo = {req_addr[1], 1'b0};
    end else if (req_size == SZ_WORD) begin
      eff_lo = 2'b00;
    end
`endif
    wr_be    = byte_en(req_size, eff_lo);
    wr_lanes = lane_wdata(req_size, req_wdata);
  end

  // Store path: lane-masked write at the accept edge; errored stores never write.
  // NOTE: the storage array has no reset; only control state is cleared, contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !req_err) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem_array[word_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
        end
      end
    end
  end

  dmem_load_align u_load_align (
    .word_i   (hold_d),
    .lo_i     (lo_d),
    .size_i   (size_d),
    .signed_i (signed_d),
    .data_o   (load_data)
  );

  // FSM next state, request capture and registered-response inputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    lo_d     = lo_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          lo_d     = eff_lo;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          err_d    = req_err;
          hold_d   = (!req_write && !req_err) ? mem_array[word_idx] : '0;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    resp_valid_d = (state_d == ST_RESP);
    resp_err_d   = resp_valid_d && err_d;
    resp_rdata_d = (resp_valid_d && !err_d && !write_d) ? load_data : '0;
  end

  // State and response registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      lo_q         <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      lo_q         <= lo_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a LATENCY=1 instance for the functional
// vectors and a LATENCY=3 instance for back-pressure and mid-flight reset.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // LATENCY = 1 instance
  logic        reset_1, req_valid_1, req_ready_1, req_write_1, req_signed_1;
  logic [1:0]  req_size_1;
  logic [31:0] req_addr_1, req_wdata_1, resp_rdata_1;
  logic        resp_valid_1, resp_err_1;

  // LATENCY = 3 instance
  logic        reset_3, req_valid_3, req_ready_3, req_write_3, req_signed_3;
  logic [1:0]  req_size_3;
  logic [31:0] req_addr_3, req_wdata_3, resp_rdata_3;
  logic        resp_valid_3, resp_err_3;

  data_mem_ctrl #(.DEPTH(256), .ADDR_W(32), .LATENCY(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset_1),
    .req_valid  (req_valid_1),
    .req_ready  (req_ready_1),
    .req_write  (req_write_1),
    .req_size   (req_size_1),
    .req_signed (req_signed_1),
    .req_addr   (req_addr_1),
    .req_wdata  (req_wdata_1),
    .resp_valid (resp_valid_1),
    .resp_rdata (resp_rdata_1),
    .resp_err   (resp_err_1)
  );

  data_mem_ctrl #(.DEPTH(256), .ADDR_W(32), .LATENCY(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset_3),
    .req_valid  (req_valid_3),
    .req_ready  (req_ready_3),
    .req_write  (req_write_3),
    .req_size   (req_size_3),
    .req_signed (req_signed_3),
    .req_addr   (req_addr_3),
    .req_wdata  (req_wdata_3),
    .resp_valid (resp_valid_3),
    .resp_rdata (resp_rdata_3),
    .resp_err   (resp_err_3)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One complete transaction on the selected instance; returns response data,
  // error flag and the number of cycles from the accept edge to resp_valid.
  task automatic access(input int which, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic rv;
    @(negedge clk);
    if (which == 1) begin
      req_write_1 = w; req_size_1 = sz; req_signed_1 = sg; req_addr_1 = a; req_wdata_1 = wd;
      req_valid_1 = 1'b1;
    end else begin
      req_write_3 = w; req_size_3 = sz; req_signed_3 = sg; req_addr_3 = a; req_wdata_3 = wd;
      req_valid_3 = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid_1 = (which == 1) ? 1'b0 : req_valid_1;
    req_valid_3 = (which == 1) ? req_valid_3 : 1'b0;
    lat = 1;
    rv  = (which == 1) ? resp_valid_1 : resp_valid_3;
    while (!rv && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      rv = (which == 1) ? resp_valid_1 : resp_valid_3;
    end
    if (!rv) check("resp_timeout", 32'(rv), 32'd1);
    rd = (which == 1) ? resp_rdata_1 : resp_rdata_3;
    er = (which == 1) ? resp_err_1 : resp_err_3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [7:0]  exp_rdy;
    logic [7:0]  exp_rv;
    logic        saw_rv;

    reset_1 = 1'b1; req_valid_1 = 1'b0; req_write_1 = 1'b0; req_size_1 = 2'b00;
    req_signed_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0;
    reset_3 = 1'b1; req_valid_3 = 1'b0; req_write_3 = 1'b0; req_size_3 = 2'b00;
    req_signed_3 = 1'b0; req_addr_3 = '0; req_wdata_3 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid_1), 32'd0);
    check("rst_resp_err",   32'(resp_err_1),   32'd0);
    check("rst_resp_rdata", resp_rdata_1,      32'h0);
    reset_1 = 1'b0;
    reset_3 = 1'b0;
    check("rst_req_ready",  32'(req_ready_1),  32'd1);

    // Word round-trip, one-cycle latency
    access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("st_word_lat",   32'(lat), 32'd1);
    check("st_word_rdata", rd,       32'h0);
    check("st_word_err",   32'(er),  32'd0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld_word_lat",   32'(lat), 32'd1);
    check("ld_word_rdata", rd,       32'hDEADBEEF);

    // Byte store over a zero word, then extension checks
    access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    access(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, rd, er, lat);
    access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("byte_word_view", rd, 32'h80000000);
    access(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
    check("ld_byte_signed", rd, 32'hFFFFFF80);
    access(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("ld_byte_unsigned", rd, 32'h00000080);

    // Half store into the upper half of a known word
    access(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, rd, er, lat);
    access(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, rd, er, lat);
    access(1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat);
    check("ld_half_signed", rd, 32'hFFFF8001);
    access(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("half_word_view", rd, 32'h80015678);
    access(1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er, lat);
    check("ld_half_low_pos", rd, 32'h00005678);
    access(1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat);
    check("ld_byte_lane1", rd, 32'h00000056);

    // Range boundary: last word is valid, the first word past the end is not
    access(1, 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h0BADCAFE, rd, er, lat);
    access(1, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, rd, er, lat);
    check("last_word_rdata", rd,      32'h0BADCAFE);
    check("last_word_err",   32'(er), 32'd0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lat);
    check("oor_400_err",   32'(er), 32'd1);
    check("oor_400_rdata", rd,      32'h0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h402, 32'h0, rd, er, lat);
    check("oor_402_err",   32'(er), 32'd1);
    check("oor_402_rdata", rd,      32'h0);

    // Reserved size: errors on load, no write on store
    access(1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("rsvd_ld_err",   32'(er), 32'd1);
    check("rsvd_ld_rdata", rd,      32'h0);
    access(1, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, rd, er, lat);
    check("rsvd_st_err", 32'(er), 32'd1);
    access(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("rsvd_st_nowrite", rd, 32'h80000000);

    // Misaligned accesses
    access(1, 1'b1, 2'b10, 1'b0, 32'h04, 32'h11111111, rd, er, lat);
    access(1, 1'b1, 2'b10, 1'b0, 32'h06, 32'hCAFEF00D, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("misal_st_err", 32'(er), 32'd1);
    access(1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, er, lat);
    check("misal_st_nowrite", rd, 32'h11111111);
    access(1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("misal_half_err",   32'(er), 32'd1);
    check("misal_half_rdata", rd,      32'h0);
`else
    check("misal_st_err", 32'(er), 32'd0);
    access(1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, rd, er, lat);
    check("misal_st_aligned", rd, 32'hCAFEF00D);
    access(1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("misal_half_err",   32'(er), 32'd0);
    check("misal_half_rdata", rd,      32'h00008000);
`endif

    // Back-pressure on the LATENCY=3 instance with req_valid held high
    exp_rdy = 8'b1000_1000;  // bit k: req_ready sampled k cycles after the first accept
    exp_rv  = 8'b0100_0100;
    @(negedge clk);
    req_write_3 = 1'b1; req_size_3 = 2'b10; req_signed_3 = 1'b0;
    req_addr_3 = 32'h30; req_wdata_3 = 32'hA5A5A5A5; req_valid_3 = 1'b1;
    check("bp_ready_idle", 32'(req_ready_3), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bp_ready_%0d", k), 32'(req_ready_3),  32'(exp_rdy[k]));
      check($sformatf("bp_valid_%0d", k), 32'(resp_valid_3), 32'(exp_rv[k]));
      if (k == 0) begin
        req_wdata_3 = 32'hBAD0BAD0;
      end
      if (k == 2) begin
        check("bp_store_rdata", resp_rdata_3, 32'h0);
        req_write_3 = 1'b0;
      end
      if (k == 3) begin
        check("bp_idle_rdata", resp_rdata_3, 32'h0);
      end
      if (k == 6) begin
        check("bp_load_rdata", resp_rdata_3,      32'hA5A5A5A5);
        check("bp_load_err",   32'(resp_err_3),   32'd0);
      end
      if (k == 7) begin
        req_valid_3 = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    // Reset while a store is waiting: response dropped, store already committed
    @(negedge clk);
    req_write_3 = 1'b1; req_size_3 = 2'b10; req_addr_3 = 32'h34;
    req_wdata_3 = 32'h00000077; req_valid_3 = 1'b1;
    @(posedge clk);
    #1;
    req_valid_3 = 1'b0;
    check("mid_in_wait", 32'(req_ready_3), 32'd0);
    reset_3 = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(resp_valid_3), 32'd0);
    check("mid_rst_err",   32'(resp_err_3),   32'd0);
    check("mid_rst_rdata", resp_rdata_3,      32'h0);
    reset_3 = 1'b0;
    check("mid_rst_ready", 32'(req_ready_3), 32'd1);
    saw_rv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      saw_rv = saw_rv | resp_valid_3;
    end
    check("mid_no_resp", 32'(saw_rv), 32'd0);
    access(3, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, rd, er, lat);
    check("mid_store_kept", rd,       32'h00000077);
    check("lat3_latency",   32'(lat), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, synchronous data memory for the pipeline's MEM stage. It supersedes the flat word-wide combinational RAM with:
- a clocked, word-organised storage array;
- byte, half-word and word loads/stores with sign or zero extension;
- a request/response handshake with configurable wait-state latency;
- error reporting for bad accesses.

Memory-stage stall logic drives `req_*` and consumes `resp_*`.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `ADDR_W`, 32: byte-address width.
- `LATENCY`, 1: cycles from accept to response; ≥ 1.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; a transfer occurs when `req_valid && req_ready` at a rising edge.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result, extended; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; the access was rejected.

## Operation
- **Storage:** `DEPTH` × 32 array. Word index = `req_addr[log2(DEPTH)+1:2]`. Little-endian byte lanes: byte k occupies bits [8k+7:8k].
- **Error conditions**, evaluated at accept:
  - `req_size` == 11;
  - `req_addr` ≥ `DEPTH*4`;
  - misalignment (see Configuration).
- **Errored store:** no array write.
- **Errored load:** `resp_rdata` = 0.
- **Store:** at the accept edge, writes only the addressed lanes.
  - byte → lane `addr[1:0]`;
  - half → lanes `addr[1]*2` and `+1`;
  - word → all four lanes.
- **Load:** at the accept edge, the addressed word is latched into a hold register. The lane is selected, then extended per `req_signed`. Word loads ignore `req_signed`.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: `req_ready` = 1. On accept, go to RESP if `LATENCY` = 1; otherwise go to WAIT with count = `LATENCY`−1.
  - WAIT: `req_ready` = 0. Count decrements each cycle; at count = 1, go to RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle, `req_ready` = 0; then go to IDLE.
- While not in IDLE, the request inputs are don't-care and are not sampled.
- **Reset:**
  - state → IDLE;
  - `resp_valid`, `resp_err`, `resp_rdata`, count, hold register → 0;
  - `req_ready` = 1 in the first cycle after reset deasserts.
  - Array contents are not reset.
- **Reset mid-operation:** the in-flight response is dropped and no `resp_valid` is issued. A store already committed at its accept edge stays committed.

## Timing
- Request accepted at edge N → `resp_valid` high during cycle N+`LATENCY`. `req_ready` returns high in cycle N+`LATENCY`+1.
- Sustained throughput is one access per `LATENCY`+1 cycles.
- `resp_rdata` and `resp_err` are registered, and are valid only while `resp_valid` is high. Outside that cycle they hold 0.
- Read-after-write to the same address is serialised by the handshake: the load always returns the stored value.

## Configuration
- **`DMEM_ALIGN_CHECK_EN` defined:**
  - a half access with `addr[0]` = 1 raises `resp_err`;
  - a word access with `addr[1:0]` ≠ 0 raises `resp_err`.
- **`DMEM_ALIGN_CHECK_EN` undefined:** the offending low address bits are forced to 0 (access silently aligned) and no misalignment error is raised. Size and range errors remain.

## Structure
- **Package `dmem_pkg`:** size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), FSM state enum, and the byte-enable function (size, `addr[1:0]` → 4-bit mask).
- **Sub-module `dmem_load_align`:** combinational lane select plus sign/zero extension. Takes the hold word, `addr[1:0]`, size and signed; returns 32-bit data.

## Test plan
- **Word round-trip:** reset, store word `0xDEADBEEF` @ `0x10`, load word @ `0x10` → `resp_rdata` = `0xDEADBEEF`. With `LATENCY` = 1, `resp_valid` arrives 1 cycle after each accept.
- **Byte store and extension:** store byte `0x80` @ `0x13` over `0x00000000`; word @ `0x10` → `0x80000000`. Signed byte load @ `0x13` → `0xFFFFFF80`; unsigned → `0x00000080`.
- **Half access:** store half `0x8001` @ `0x22`; signed half load @ `0x22` → `0xFFFF8001`; word @ `0x20` → `0x8001xxxx`, with the low half unchanged.
- **Errors:**
  - word load @ `0x402` with `DEPTH` = 256 → `resp_err` = 1, `resp_rdata` = 0;
  - size 11 → `resp_err` = 1;
  - misaligned word store @ `0x06` with the macro defined → `resp_err` = 1 and the array is unchanged;
  - same store without the macro → writes word `0x04`, `resp_err` = 0.
- **Latency and back-pressure:** with `LATENCY` = 3, hold `req_valid` high continuously. Verify `req_ready` is low for 3 cycles after each accept, one `resp_valid` arrives per 4 cycles, and inputs changed while busy are ignored.
- **Reset mid-flight:** `LATENCY` = 3, accept a load, assert `reset` in the WAIT state. Verify no `resp_valid` is issued, all outputs are 0, and `req_ready` = 1 the cycle after reset drops.
